// File: rtl/acs_butterfly.sv
// Add-compare-select butterfly for a 64-state K=7 Viterbi path metric unit.
// Produces registered metrics/decisions for successor states j (lo) and j+32 (hi).
module acs_butterfly #(
    parameter int PM_W      = 8,
    parameter bit IS_STATE0 = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            init,
    input  logic            norm,
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      bm_a0,
    input  logic [1:0]      bm_a1,
    input  logic [1:0]      bm_b0,
    input  logic [1:0]      bm_b1,
    output logic [PM_W-1:0] pm_lo,
    output logic [PM_W-1:0] pm_hi,
    output logic            dec_lo,
    output logic            dec_hi,
    output logic            out_valid,
    output logic            pm_msb
);

    localparam logic [PM_W-1:0] MAX     = {PM_W{1'b1}};
    localparam logic [PM_W-1:0] HALF    = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0] LO_INIT = IS_STATE0 ? {PM_W{1'b0}} : MAX;

    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm,
                                                input logic [1:0]      bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
        return sum[PM_W] ? MAX : sum[PM_W-1:0];
    endfunction

    function automatic logic [PM_W-1:0] norm_sub(input logic [PM_W-1:0] pm);
        return (pm >= HALF) ? (pm - HALF) : {PM_W{1'b0}};
    endfunction

    logic [PM_W-1:0] lo_a, lo_b, hi_a, hi_b;
    logic [PM_W-1:0] lo_win, hi_win;
    logic            lo_sel_b, hi_sel_b;

    logic [PM_W-1:0] pm_lo_q, pm_lo_d;
    logic [PM_W-1:0] pm_hi_q, pm_hi_d;
    logic            dec_lo_q, dec_lo_d;
    logic            dec_hi_q, dec_hi_d;
    logic            out_valid_q, out_valid_d;

    // Strict less-than: ties resolve to the a path with decision 0.
    always_comb begin
        lo_a     = sat_add(pm_a, bm_a0);
        lo_b     = sat_add(pm_b, bm_b0);
        hi_a     = sat_add(pm_a, bm_a1);
        hi_b     = sat_add(pm_b, bm_b1);
        lo_sel_b = (lo_b < lo_a);
        hi_sel_b = (hi_b < hi_a);
        lo_win   = lo_sel_b ? lo_b : lo_a;
        hi_win   = hi_sel_b ? hi_b : hi_a;
    end

    always_comb begin
        pm_lo_d     = pm_lo_q;
        pm_hi_d     = pm_hi_q;
        dec_lo_d    = dec_lo_q;
        dec_hi_d    = dec_hi_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            if (init) begin
                pm_lo_d  = LO_INIT;
                pm_hi_d  = MAX;
                dec_lo_d = 1'b0;
                dec_hi_d = 1'b0;
            end else begin
                pm_lo_d  = norm ? norm_sub(lo_win) : lo_win;
                pm_hi_d  = norm ? norm_sub(hi_win) : hi_win;
                dec_lo_d = lo_sel_b;
                dec_hi_d = hi_sel_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_lo_q     <= LO_INIT;
            pm_hi_q     <= MAX;
            dec_lo_q    <= 1'b0;
            dec_hi_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            pm_lo_q     <= pm_lo_d;
            pm_hi_q     <= pm_hi_d;
            dec_lo_q    <= dec_lo_d;
            dec_hi_q    <= dec_hi_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign pm_lo     = pm_lo_q;
    assign pm_hi     = pm_hi_q;
    assign dec_lo    = dec_lo_q;
    assign dec_hi    = dec_hi_q;
    assign out_valid = out_valid_q;
    assign pm_msb    = pm_lo_q[PM_W-1] & pm_hi_q[PM_W-1];

endmodule

// File: tb/tb_acs_butterfly.sv
// Directed bench for acs_butterfly: table vectors, hold/init corner cases,
// and random back-to-back steps interrupted by an asynchronous reset.
module tb_acs_butterfly;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, init = 1'b0, norm = 1'b0;
    logic [7:0] pm_a = '0, pm_b = '0;
    logic [1:0] bm_a0 = '0, bm_a1 = '0, bm_b0 = '0, bm_b1 = '0;

    logic [7:0] pm_lo0, pm_hi0, pm_lo1, pm_hi1;
    logic       dec_lo0, dec_hi0, ov0, msb0;
    logic       dec_lo1, dec_hi1, ov1, msb1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    acs_butterfly #(.PM_W(8), .IS_STATE0(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .init(init), .norm(norm),
        .pm_a(pm_a), .pm_b(pm_b), .bm_a0(bm_a0), .bm_a1(bm_a1),
        .bm_b0(bm_b0), .bm_b1(bm_b1),
        .pm_lo(pm_lo0), .pm_hi(pm_hi0), .dec_lo(dec_lo0), .dec_hi(dec_hi0),
        .out_valid(ov0), .pm_msb(msb0));

    acs_butterfly #(.PM_W(8), .IS_STATE0(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .init(init), .norm(norm),
        .pm_a(pm_a), .pm_b(pm_b), .bm_a0(bm_a0), .bm_a1(bm_a1),
        .bm_b0(bm_b0), .bm_b1(bm_b1),
        .pm_lo(pm_lo1), .pm_hi(pm_hi1), .dec_lo(dec_lo1), .dec_hi(dec_hi1),
        .out_valid(ov1), .pm_msb(msb1));

    typedef struct {
        bit init; bit norm;
        int pa; int pb; int a0; int a1; int b0; int b1;
        int lo; int hi; bit dl; bit dh;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit i, input bit n, input int pa, input int pb,
                         input int a0, input int a1, input int b0, input int b1);
        in_valid = v; init = i; norm = n;
        pm_a = 8'(pa); pm_b = 8'(pb);
        bm_a0 = 2'(a0); bm_a1 = 2'(a1); bm_b0 = 2'(b0); bm_b1 = 2'(b1);
    endtask

    // Independent integer reference for the IS_STATE0=1 instance.
    task automatic model(input bit i, input bit n, input int pa, input int pb,
                         input int a0, input int a1, input int b0, input int b1,
                         output int lo, output int hi, output bit dl, output bit dh);
        int la, lb, ha, hb;
        if (i) begin
            lo = 0; hi = 255; dl = 0; dh = 0;
        end else begin
            la = (pa + a0 > 255) ? 255 : pa + a0;
            lb = (pb + b0 > 255) ? 255 : pb + b0;
            ha = (pa + a1 > 255) ? 255 : pa + a1;
            hb = (pb + b1 > 255) ? 255 : pb + b1;
            dl = (lb < la);
            dh = (hb < ha);
            lo = dl ? lb : la;
            hi = dh ? hb : ha;
            if (n) begin
                lo = (lo < 128) ? 0 : lo - 128;
                hi = (hi < 128) ? 0 : hi - 128;
            end
        end
    endtask

    task automatic chk_out(input string tag, input int lo, input int hi,
                           input bit dl, input bit dh, input bit ov);
        chk({tag, ".pm_lo"},     int'(pm_lo0),  lo);
        chk({tag, ".pm_hi"},     int'(pm_hi0),  hi);
        chk({tag, ".dec_lo"},    int'(dec_lo0), int'(dl));
        chk({tag, ".dec_hi"},    int'(dec_hi0), int'(dh));
        chk({tag, ".out_valid"}, int'(ov0),     int'(ov));
        chk({tag, ".pm_msb"},    int'(msb0),    int'((lo >= 128) && (hi >= 128)));
    endtask

    initial begin
        int lo, hi, lo1;
        bit dl, dh;
        int ra, rb, r0, r1, r2, r3;
        bit rn, ri;

        vt[0] = '{0, 0,  10,   7, 0, 2, 2, 0,   9,   7, 1, 1};
        vt[1] = '{0, 0,   5,   4, 1, 0, 2, 2,   6,   5, 0, 0};
        vt[2] = '{0, 0, 254, 254, 0, 2, 1, 2, 254, 255, 0, 0};
        vt[3] = '{0, 0, 255, 254, 2, 1, 0, 1, 254, 255, 1, 0};
        vt[4] = '{0, 1, 200, 150, 1, 1, 1, 1,  23,  23, 1, 1};
        vt[5] = '{0, 1, 100, 110, 0, 0, 0, 0,   0,   0, 0, 0};
        vt[6] = '{1, 1,  37,  12, 2, 0, 1, 2,   0, 255, 0, 0};
        vt[7] = '{0, 1, 130, 130, 2, 0, 2, 1,   4,   2, 0, 0};
        vt[8] = '{0, 0,  20,  19, 0, 2, 2, 0,  20,  19, 0, 1};
        vt[9] = '{0, 1, 128, 200, 0, 1, 0, 0,   0,   1, 0, 0};

        // Reset values, both instance flavours.
        #12;
        chk_out("reset", 0, 255, 0, 0, 0);
        chk("reset1.pm_lo",  int'(pm_lo1), 255);
        chk("reset1.pm_msb", int'(msb1),   1);
        @(negedge clk) rst_n = 1'b1;

        // Table vectors, applied back-to-back.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1, vt[k].init, vt[k].norm, vt[k].pa, vt[k].pb,
                  vt[k].a0, vt[k].a1, vt[k].b0, vt[k].b1);
            @(posedge clk); #1;
            chk_out($sformatf("vec%0d", k), vt[k].lo, vt[k].hi, vt[k].dl, vt[k].dh, 1);
            lo1 = vt[k].init ? 255 : vt[k].lo;
            chk($sformatf("vec%0d.pm_lo1", k), int'(pm_lo1), lo1);
            chk($sformatf("vec%0d.pm_hi1", k), int'(pm_hi1), vt[k].hi);
        end

        // Basic step then an idle cycle: values hold, out_valid drops.
        @(negedge clk) drive(1, 0, 0, 10, 7, 0, 2, 2, 0);
        @(posedge clk); #1;
        chk_out("basic", 9, 7, 1, 1, 1);
        @(negedge clk) drive(0, 0, 0, 99, 3, 2, 2, 2, 2);
        @(posedge clk); #1;
        chk_out("idle", 9, 7, 1, 1, 0);

        // init without in_valid is ignored.
        @(negedge clk) drive(0, 1, 1, 50, 60, 1, 1, 1, 1);
        @(posedge clk); #1;
        chk_out("init_novalid", 9, 7, 1, 1, 0);

        // Random back-to-back steps checked against the model.
        for (int k = 0; k < 10; k++) begin
            ra = $urandom_range(255); rb = $urandom_range(255);
            r0 = $urandom_range(2); r1 = $urandom_range(2);
            r2 = $urandom_range(2); r3 = $urandom_range(2);
            rn = 1'($urandom_range(1)); ri = ($urandom_range(7) == 0);
            @(negedge clk) drive(1, ri, rn, ra, rb, r0, r1, r2, r3);
            model(ri, rn, ra, rb, r0, r1, r2, r3, lo, hi, dl, dh);
            @(posedge clk); #1;
            chk_out($sformatf("rand%0d", k), lo, hi, dl, dh, 1);
        end

        // Asynchronous reset between edges, mid-stream.
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 255, 0, 0, 0);
        chk("async_rst1.pm_lo", int'(pm_lo1), 255);
        @(negedge clk) rst_n = 1'b1;
        drive(1, 0, 0, 40, 41, 2, 1, 0, 2);
        model(0, 0, 40, 41, 2, 1, 0, 2, lo, hi, dl, dh);
        @(posedge clk); #1;
        chk_out("post_rst", lo, hi, dl, dh, 1);
        chk("post_rst.pm_lo_hand", int'(pm_lo0), 41);
        @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("post_rst.ov_drop", int'(ov0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acs_butterfly.md
# acs_butterfly

Add-compare-select butterfly for the rate-1/2, K=7, 64-state hard-decision Viterbi decoder. It consumes the 2-bit Hamming branch metrics produced by the two branch-metric cells of predecessor states 2j and 2j+1, plus their path metrics. It produces registered path metrics and survivor decision bits for successor states j (lo) and j+32 (hi). Thirty-two instances form the path metric unit; decisions feed the traceback memory and the normalization flags feed the PMU controller.

## Interface
- `PM_W`, default 8: path metric width in bits, minimum 4.
- `IS_STATE0`, default 0: 1 only for the j=0 instance. Selects the init/reset value of the lo metric.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: inputs below carry one trellis step.
- `init`, input, 1: frame start. Sampled only with `in_valid`.
- `norm`, input, 1: subtract 2^(PM_W-1) this step. Sampled only with `in_valid`.
- `pm_a`, input, PM_W: path metric of predecessor 2j.
- `pm_b`, input, PM_W: path metric of predecessor 2j+1.
- `bm_a0`, `bm_a1`, input, 2 each: branch metrics from predecessor 2j for input bit 0/1 (range 0..2).
- `bm_b0`, `bm_b1`, input, 2 each: branch metrics from predecessor 2j+1 for input bit 0/1.
- `pm_lo`, output, PM_W: registered metric of state j.
- `pm_hi`, output, PM_W: registered metric of state j+32.
- `dec_lo`, `dec_hi`, output, 1 each: survivor select, 1 = came from 2j+1.
- `out_valid`, output, 1: registered outputs updated this cycle.
- `pm_msb`, output, 1: combinational AND of `pm_lo[PM_W-1]` and `pm_hi[PM_W-1]`.

## Operation
- `MAX` = 2^PM_W - 1. `HALF` = 2^(PM_W-1).
- Candidate sums are computed at PM_W+1 bits and saturated to `MAX`:
  - `lo_a = pm_a + bm_a0`, `lo_b = pm_b + bm_b0`
  - `hi_a = pm_a + bm_a1`, `hi_b = pm_b + bm_b1`
- Compare uses the saturated values. The smaller metric wins. On a tie the `a` path wins and dec = 0.
- If `norm` is set, `HALF` is subtracted from each winner, clamped at 0. The controller asserts `norm` only when every instance shows `pm_msb` = 1; the clamp is a safety net.
- `init` has priority over `norm` and over the compare:
  - `pm_lo` loads 0 if `IS_STATE0`, else `MAX`.
  - `pm_hi` loads `MAX`.
  - `dec_lo` and `dec_hi` load 0.
  - The other inputs are ignored that step.
- When `in_valid` = 0, all registers hold, except `out_valid`, which drops to 0.
- Reset values:
  - `pm_lo` = 0 if `IS_STATE0`, else `MAX`; `pm_hi` = `MAX`.
  - `dec_lo` = `dec_hi` = `out_valid` = 0.
  - Therefore `pm_msb` = 1 after reset in every instance except j=0.
- There is no internal FSM beyond the hold/update/init register behaviour. There is no backpressure: the downstream consumer must accept every `out_valid` pulse.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N, with `out_valid` high for exactly that cycle.
- Throughput is one trellis step per cycle. Back-to-back `in_valid` is supported.
- `pm_lo` and `pm_hi` of step N are fed back by the PMU as `pm_a`/`pm_b` of step N+1, so the full add-compare-subtract path must close in one cycle.
- Asserting `rst_n` low mid-frame immediately forces the reset values, regardless of `clk`. The first `in_valid` after release is processed normally, with or without `init`.
- `init` and `norm` in the same valid cycle: `init` wins and no subtraction is applied.
- Saturation: if both candidates saturate to `MAX`, the tie rule applies (dec = 0, metric = `MAX`).

## Test plan
All scenarios use `PM_W` = 8, `IS_STATE0` = 1.
- **Reset:** hold `rst_n` low → `pm_lo` = 0, `pm_hi` = 255, `dec_lo` = `dec_hi` = `out_valid` = 0, `pm_msb` = 0. Repeat with `IS_STATE0` = 0 → `pm_lo` = 255, `pm_msb` = 1.
- **Basic ACS:** `pm_a` = 10, `pm_b` = 7, `bm_a0` = 0, `bm_b0` = 2, `bm_a1` = 2, `bm_b1` = 0, valid → next cycle `pm_lo` = 9, `dec_lo` = 1, `pm_hi` = 7, `dec_hi` = 1, `out_valid` = 1. Following idle cycle → `out_valid` = 0, values held.
- **Tie and saturation:** `pm_a` = 5, `pm_b` = 4, `bm_a0` = 1, `bm_b0` = 2 → `pm_lo` = 6, `dec_lo` = 0. Then `pm_a` = `pm_b` = 254, `bm_a1` = `bm_b1` = 2 → `pm_hi` = 255, `dec_hi` = 0.
- **Normalization:** `pm_a` = 200, `pm_b` = 150, all bm = 1, `norm` = 1 → `pm_lo` = `pm_hi` = 23, `dec` = 1. Then `pm_a` = 100, `pm_b` = 110, bm = 0, `norm` = 1 → clamp to 0, `dec` = 0.
- **Init priority:** `init` = 1 and `norm` = 1 with arbitrary inputs → `pm_lo` = 0, `pm_hi` = 255, decisions 0. `init` with `in_valid` = 0 → no change.
- **Async reset mid-stream:** 10 random back-to-back steps, drop `rst_n` between edges → outputs reach reset values before the next edge. Release, then one valid step → normal result one cycle later. Compare every step against a behavioural model.
